pipelined_cla_adder: RTL

- Parametrised, pipelined successor to the team's combinational carry-lookahead adder.
- Splits a WIDTH-bit add/subtract into NSEG = WIDTH/SEG segments. Each segment is a SEG-bit lookahead adder in its own pipeline stage, and carries are registered between stages.
- Adds a valid/ready handshake, a per-operation add/sub mode, and carry/overflow flags.
- Used as the final adder after the Booth/Wallace reduction tree, and wherever a wide add must meet timing.

---
 rtl/pipelined_cla_adder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined WIDTH-bit carry-lookahead add/subtract: one SEG-bit lookahead segment per stage, global valid/ready stall.
// Optional build macro PIPELINED_CLA_SAT_EN: signed saturation of s on overflow, muxed in the last stage.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSEG = (SEG == 0) ? 1 : WIDTH / SEG;

  if (SEG < 1) begin : g_chk_seg
    $error("pipelined_cla_adder: SEG must be at least 1");
  end else if (WIDTH % SEG != 0) begin : g_chk_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of SEG");
  end

  // One enable for the whole pipe: stages only hold when a valid result is stuck at the output.
  logic adv_c;
  assign adv_c    = out_ready | ~out_valid;
  assign in_ready = adv_c;

  // Subtract is A + ~B + 1; cin is ignored in that mode.
  logic [WIDTH-1:0] bx_c;
  logic             c0_c;
  assign bx_c = b ^ {WIDTH{sub}};
  assign c0_c = sub | cin;

  // SEG-bit lookahead segment; returns {carry_out, sum}.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[SEG], p ^ c[SEG-1:0]};
  endfunction

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic [SEG-1:0]       sa_c;
    logic [SEG-1:0]       sb_c;
    logic                 sci_c;
    logic                 sv_c;
    logic [SEG:0]         sr_c;
    logic [(k+1)*SEG-1:0] res_c;

    assign sr_c = seg_add(sa_c, sb_c, sci_c);

    // Segment operands come from the input beat or from the previous stage's skew registers.
    if (k == 0) begin : g_src
      assign sa_c  = a[SEG-1:0];
      assign sb_c  = bx_c[SEG-1:0];
      assign sci_c = c0_c;
      assign sv_c  = in_valid;
      assign res_c = sr_c[SEG-1:0];
    end else begin : g_src
      assign sa_c  = g_stage[k-1].g_reg.a_q[SEG-1:0];
      assign sb_c  = g_stage[k-1].g_reg.b_q[SEG-1:0];
      assign sci_c = g_stage[k-1].g_reg.c_q;
      assign sv_c  = g_stage[k-1].g_reg.v_q;
      assign res_c = {sr_c[SEG-1:0], g_stage[k-1].g_reg.r_q};
    end

    if (k < NSEG - 1) begin : g_reg
      localparam int unsigned HW = WIDTH - (k + 1) * SEG;
      logic                 v_q;
      logic                 c_q;
      logic [(k+1)*SEG-1:0] r_q;
      logic [HW-1:0]        a_q;
      logic [HW-1:0]        b_q;
      logic [HW-1:0]        na_c;
      logic [HW-1:0]        nb_c;

      if (k == 0) begin : g_op
        assign na_c = a[WIDTH-1:SEG];
        assign nb_c = bx_c[WIDTH-1:SEG];
      end else begin : g_op
        assign na_c = g_stage[k-1].g_reg.a_q[HW+SEG-1:SEG];
        assign nb_c = g_stage[k-1].g_reg.b_q[HW+SEG-1:SEG];
      end

      // Stage register: valid, segment carry, finished low result bits, untouched high operands.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          r_q <= '0;
          a_q <= '0;
          b_q <= '0;
        end else if (adv_c) begin
          v_q <= sv_c;
          c_q <= sr_c[SEG];
          r_q <= res_c;
          a_q <= na_c;
          b_q <= nb_c;
        end
      end
    end else begin : g_out
      logic             ovf_c;
      logic [WIDTH-1:0] s_nx_c;

      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      assign ovf_c = sa_c[SEG-1] ^ sb_c[SEG-1] ^ sr_c[SEG-1] ^ sr_c[SEG];

`ifdef PIPELINED_CLA_SAT_EN
      logic [WIDTH-1:0] smin_c;
      always_comb begin
        smin_c           = '0;
        smin_c[WIDTH-1]  = 1'b1;
      end
      assign s_nx_c = !ovf_c      ? res_c  :
                      sa_c[SEG-1] ? smin_c : ~smin_c;
`else
      assign s_nx_c = res_c;
`endif

      // Output register: bubbles clear out_valid but leave the last result in place.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          s         <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
        end else if (adv_c) begin
          out_valid <= sv_c;
          if (sv_c) begin
            s    <= s_nx_c;
            cout <= sr_c[SEG];
            ovf  <= ovf_c;
          end
        end
      end
    end
  end

endmodule
